// File: rtl/branch_predict_resolve_unit.sv
// Execute-stage resolver for JAL/JALR/conditional branches with a direct-mapped
// branch history/target table looked up by fetch and registered redirect/flush.
module branch_predict_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              fetch_pred_taken,
    output logic [ADDR_W-1:0] fetch_pred_target,
    input  logic              valid_in,
    input  logic [XLEN-1:0]   pc,
    input  logic [31:0]       instruction,
    input  logic [XLEN-1:0]   first_operand,
    input  logic [XLEN-1:0]   second_operand,
    input  logic              predicted_taken,
    input  logic [ADDR_W-1:0] predicted_target,
    input  logic              clear_counters,
    output logic              resolved_valid,
    output logic              the_branch_is_taken,
    output logic [ADDR_W-1:0] address_to_branch,
    output logic [ADDR_W-1:0] return_address,
    output logic              return_address_usage,
    output logic [4:0]        return_address_reg,
    output logic              flush_indicator,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  mispredict_count
);

    localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

    typedef enum logic [6:0] {
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011
    } opcode_e;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              is_jal, is_jalr, is_br, ctrl;
    logic [XLEN-1:0]   imm_j, imm_i, imm_b, tgt_full, pc_plus4;
    logic              taken, mispredict;
    logic [ADDR_W-1:0] tgt;
    logic [IDX_W-1:0]  look_idx, upd_idx;
    logic [1:0]        ctr_d;

    logic              bht_valid_q [BHT_ENTRIES];
    logic [1:0]        bht_ctr_q   [BHT_ENTRIES];
    logic [ADDR_W-1:0] bht_tgt_q   [BHT_ENTRIES];

    logic              res_q, res_d, tk_q, tk_d, rau_q, rau_d, fl_q, fl_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ra_q, ra_d;
    logic [4:0]        rar_q, rar_d;
    logic [CNT_W-1:0]  bc_q, bc_d, mc_q, mc_d;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign is_jal  = (opcode == OP_JAL);
    assign is_jalr = (opcode == OP_JALR);
    assign is_br   = (opcode == OP_BRANCH) && (funct3 != 3'b010) && (funct3 != 3'b011);
    // The instruction behind a flush is wrong-path, so it is never resolved.
    assign ctrl    = valid_in && !fl_q && (is_jal || is_jalr || is_br);

    assign imm_j = {{(XLEN-21){instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
    assign imm_b = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};

    assign pc_plus4 = pc + XLEN'(4);

    always_comb begin
        tgt_full = pc + imm_b;
        if (is_jal) begin
            tgt_full = pc + imm_j;
        end else if (is_jalr) begin
            tgt_full = (first_operand + imm_i) & ~XLEN'(1);
        end
    end
    assign tgt = tgt_full[ADDR_W-1:0];

    always_comb begin
        taken = 1'b1;
        if (is_br) begin
            unique case (funct3)
                3'b000:  taken = (first_operand == second_operand);
                3'b001:  taken = (first_operand != second_operand);
                3'b100:  taken = ($signed(first_operand) <  $signed(second_operand));
                3'b101:  taken = ($signed(first_operand) >= $signed(second_operand));
                3'b110:  taken = (first_operand <  second_operand);
                default: taken = (first_operand >= second_operand);
            endcase
        end
    end

    assign mispredict = (taken != predicted_taken) || (taken && (tgt != predicted_target));

    assign look_idx = fetch_pc[IDX_W+1:2];
    assign upd_idx  = pc[IDX_W+1:2];

    assign fetch_pred_taken  = bht_valid_q[look_idx] & bht_ctr_q[look_idx][1];
    assign fetch_pred_target = bht_valid_q[look_idx] ? bht_tgt_q[look_idx] : '0;

    always_comb begin
        ctr_d = bht_ctr_q[upd_idx];
        if (is_jal || is_jalr) begin
            ctr_d = 2'b11;
        end else if (taken) begin
            if (ctr_d != 2'b11) ctr_d = ctr_d + 2'd1;
        end else begin
            if (ctr_d != 2'b00) ctr_d = ctr_d - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_valid_q[i] <= 1'b0;
                bht_ctr_q[i]   <= 2'b01;
                bht_tgt_q[i]   <= '0;
            end
        end else if (ctrl) begin
            bht_ctr_q[upd_idx] <= ctr_d;
            if (taken) begin
                bht_valid_q[upd_idx] <= 1'b1;
                bht_tgt_q[upd_idx]   <= tgt;
            end
        end
    end

    always_comb begin
        res_d  = ctrl;
        tk_d   = ctrl && taken;
        addr_d = '0;
        ra_d   = '0;
        rau_d  = 1'b0;
        rar_d  = '0;
        fl_d   = ctrl && mispredict;
        if (ctrl) begin
            addr_d = taken ? tgt : pc_plus4[ADDR_W-1:0];
            if (is_jal || is_jalr) begin
                ra_d  = pc_plus4[ADDR_W-1:0];
                rau_d = 1'b1;
                rar_d = instruction[11:7];
            end
        end
        bc_d = bc_q;
        mc_d = mc_q;
        if (clear_counters) begin
            bc_d = '0;
            mc_d = '0;
        end else begin
            if (res_d && (bc_q != '1)) bc_d = bc_q + 1'b1;
            if (fl_d  && (mc_q != '1)) mc_d = mc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_q  <= 1'b0;
            tk_q   <= 1'b0;
            addr_q <= '0;
            ra_q   <= '0;
            rau_q  <= 1'b0;
            rar_q  <= '0;
            fl_q   <= 1'b0;
            bc_q   <= '0;
            mc_q   <= '0;
        end else begin
            res_q  <= res_d;
            tk_q   <= tk_d;
            addr_q <= addr_d;
            ra_q   <= ra_d;
            rau_q  <= rau_d;
            rar_q  <= rar_d;
            fl_q   <= fl_d;
            bc_q   <= bc_d;
            mc_q   <= mc_d;
        end
    end

    assign resolved_valid       = res_q;
    assign the_branch_is_taken  = tk_q;
    assign address_to_branch    = addr_q;
    assign return_address       = ra_q;
    assign return_address_usage = rau_q;
    assign return_address_reg   = rar_q;
    assign flush_indicator      = fl_q;
    assign branch_count         = bc_q;
    assign mispredict_count     = mc_q;

    logic unused_bits;
    assign unused_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0],
                           tgt_full[XLEN-1:ADDR_W], pc_plus4[XLEN-1:ADDR_W]};

endmodule

// File: tb/tb_branch_predict_resolve_unit.sv
// Directed bench: expected results are queued when each instruction is driven
// and popped/checked one cycle later; fetch-side lookups are checked directly.
module tb_branch_predict_resolve_unit;

    localparam int unsigned CW = 4;

    logic              clk, reset;
    logic [31:0]       fetch_pc;
    logic              fetch_pred_taken;
    logic [7:0]        fetch_pred_target;
    logic              valid_in;
    logic [31:0]       pc, instruction, first_operand, second_operand;
    logic              predicted_taken;
    logic [7:0]        predicted_target;
    logic              clear_counters;
    logic              resolved_valid, the_branch_is_taken;
    logic [7:0]        address_to_branch, return_address;
    logic              return_address_usage;
    logic [4:0]        return_address_reg;
    logic              flush_indicator;
    logic [CW-1:0]     branch_count, mispredict_count;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;
    logic [CW-1:0] m_bc = '0;
    logic [CW-1:0] m_mc = '0;

    typedef struct {
        logic       res, tk;
        logic [7:0] addr, ra;
        logic       rau;
        logic [4:0] rar;
        logic       fl;
        logic [CW-1:0] bc, mc;
    } exp_t;
    exp_t sb[$];

    branch_predict_resolve_unit #(.XLEN(32), .ADDR_W(8), .BHT_ENTRIES(16), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target),
        .valid_in(valid_in), .pc(pc), .instruction(instruction),
        .first_operand(first_operand), .second_operand(second_operand),
        .predicted_taken(predicted_taken), .predicted_target(predicted_target),
        .clear_counters(clear_counters), .resolved_valid(resolved_valid),
        .the_branch_is_taken(the_branch_is_taken), .address_to_branch(address_to_branch),
        .return_address(return_address), .return_address_usage(return_address_usage),
        .return_address_reg(return_address_reg), .flush_indicator(flush_indicator),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd3, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic look(input logic [31:0] fpc, input logic et, input logic [7:0] etg);
        fetch_pc = fpc;
        #1;
        chk("fetch_pred_taken", {31'd0, fetch_pred_taken}, {31'd0, et});
        chk("fetch_pred_target", {24'd0, fetch_pred_target}, {24'd0, etg});
    endtask

    task automatic step(input logic v, input logic [31:0] p, input logic [31:0] ins,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic pt, input logic [7:0] ptg, input logic clr,
                        input logic e_res, input logic e_tk, input logic [7:0] e_addr,
                        input logic [7:0] e_ra, input logic e_rau, input logic [4:0] e_rar,
                        input logic e_fl);
        exp_t e;
        exp_t g;
        @(negedge clk);
        valid_in = v; pc = p; instruction = ins;
        first_operand = a; second_operand = b;
        predicted_taken = pt; predicted_target = ptg; clear_counters = clr;
        if (clr) begin
            m_bc = '0;
            m_mc = '0;
        end else begin
            if (e_res && m_bc != '1) m_bc = m_bc + 1'b1;
            if (e_fl  && m_mc != '1) m_mc = m_mc + 1'b1;
        end
        e.res = e_res; e.tk = e_tk; e.addr = e_addr; e.ra = e_ra;
        e.rau = e_rau; e.rar = e_rar; e.fl = e_fl; e.bc = m_bc; e.mc = m_mc;
        sb.push_back(e);
        @(posedge clk);
        #1;
        valid_in = 1'b0; clear_counters = 1'b0;
        g = sb.pop_front();
        chk("resolved_valid", {31'd0, resolved_valid}, {31'd0, g.res});
        chk("taken", {31'd0, the_branch_is_taken}, {31'd0, g.tk});
        chk("address_to_branch", {24'd0, address_to_branch}, {24'd0, g.addr});
        chk("return_address", {24'd0, return_address}, {24'd0, g.ra});
        chk("return_address_usage", {31'd0, return_address_usage}, {31'd0, g.rau});
        chk("return_address_reg", {27'd0, return_address_reg}, {27'd0, g.rar});
        chk("flush_indicator", {31'd0, flush_indicator}, {31'd0, g.fl});
        chk("branch_count", {28'd0, branch_count}, {28'd0, g.bc});
        chk("mispredict_count", {28'd0, mispredict_count}, {28'd0, g.mc});
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0,
             1'b0, 1'b0, 8'h0, 8'h0, 1'b0, 5'd0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; fetch_pc = '0; valid_in = 1'b0; pc = '0; instruction = '0;
        first_operand = '0; second_operand = '0; predicted_taken = 1'b0;
        predicted_target = '0; clear_counters = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_resolved_valid", {31'd0, resolved_valid}, 32'd0);
        chk("rst_flush", {31'd0, flush_indicator}, 32'd0);
        look(32'h40, 1'b0, 8'h00);
        idle();

        // BEQ taken, predicted not-taken: mispredict
        step(1'b1, 32'h10, enc_b(3'b000, 13'd8), 32'd5, 32'd5, 1'b0, 8'h00, 1'b0,
             1'b1, 1'b1, 8'h18, 8'h00, 1'b0, 5'd0, 1'b1);
        idle();
        look(32'h10, 1'b1, 8'h18);
        step(1'b1, 32'h10, enc_b(3'b000, 13'd8), 32'd5, 32'd5, 1'b1, 8'h18, 1'b0,
             1'b1, 1'b1, 8'h18, 8'h00, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h10, enc_b(3'b000, 13'd8), 32'd5, 32'd5, 1'b1, 8'h18, 1'b0,
             1'b1, 1'b1, 8'h18, 8'h00, 1'b0, 5'd0, 1'b0);
        // Not taken from ctr=3 -> ctr=2, still predicts taken
        step(1'b1, 32'h10, enc_b(3'b000, 13'd8), 32'd5, 32'd6, 1'b1, 8'h18, 1'b0,
             1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 5'd0, 1'b1);
        idle();
        look(32'h10, 1'b1, 8'h18);
        // ctr=1: valid entry predicts not-taken but still reports its target
        step(1'b1, 32'h10, enc_b(3'b000, 13'd8), 32'd5, 32'd6, 1'b1, 8'h18, 1'b0,
             1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 5'd0, 1'b1);
        idle();
        look(32'h10, 1'b0, 8'h18);

        // JALR: (0x100 + 3) & ~1 = 0x102 -> 0x02
        step(1'b1, 32'h20, enc_jalr(5'd1, 12'd3), 32'h100, 32'h0, 1'b0, 8'h00, 1'b0,
             1'b1, 1'b1, 8'h02, 8'h24, 1'b1, 5'd1, 1'b1);
        // Wrong-path instruction during flush must be ignored
        step(1'b1, 32'h30, enc_b(3'b000, 13'd8), 32'd5, 32'd5, 1'b0, 8'h00, 1'b0,
             1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b0);
        look(32'h30, 1'b0, 8'h00);
        look(32'h20, 1'b1, 8'h02);

        step(1'b1, 32'h50, enc_b(3'b100, 13'h20), 32'hFFFF_FFFF, 32'd1, 1'b1, 8'h70, 1'b0,
             1'b1, 1'b1, 8'h70, 8'h00, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h54, enc_b(3'b110, 13'h20), 32'hFFFF_FFFF, 32'd1, 1'b0, 8'h00, 1'b0,
             1'b1, 1'b0, 8'h58, 8'h00, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h80, enc_b(3'b001, 13'h1FF0), 32'd1, 32'd2, 1'b1, 8'h70, 1'b0,
             1'b1, 1'b1, 8'h70, 8'h00, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h60, enc_jal(5'd5, 21'h100), 32'h0, 32'h0, 1'b1, 8'h60, 1'b0,
             1'b1, 1'b1, 8'h60, 8'h64, 1'b1, 5'd5, 1'b0);
        step(1'b1, 32'h84, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 8'h00, 1'b0,
             1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b0);
        step(1'b1, 32'h88, enc_b(3'b010, 13'd8), 32'd5, 32'd5, 1'b0, 8'h00, 1'b0,
             1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 5'd0, 1'b0);

        // Drive both counters into saturation
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h90, enc_b(3'b000, 13'd8), 32'd5, 32'd5, 1'b0, 8'h00, 1'b0,
                 1'b1, 1'b1, 8'h98, 8'h00, 1'b0, 5'd0, 1'b1);
            idle();
        end
        chk("mispredict_saturated", {28'd0, mispredict_count}, {28'd0, {CW{1'b1}}});
        chk("branch_saturated", {28'd0, branch_count}, {28'd0, {CW{1'b1}}});

        // Clear wins over a simultaneous resolution
        step(1'b1, 32'h90, enc_b(3'b000, 13'd8), 32'd5, 32'd5, 1'b0, 8'h00, 1'b1,
             1'b1, 1'b1, 8'h98, 8'h00, 1'b0, 5'd0, 1'b1);
        idle();
        step(1'b1, 32'h90, enc_b(3'b101, 13'd8), 32'd3, 32'd3, 1'b1, 8'h98, 1'b0,
             1'b1, 1'b1, 8'h98, 8'h00, 1'b0, 5'd0, 1'b0);

        // Async reset with a flush pending
        step(1'b1, 32'h10, enc_b(3'b111, 13'd8), 32'd1, 32'd2, 1'b1, 8'h18, 1'b0,
             1'b1, 1'b0, 8'h14, 8'h00, 1'b0, 5'd0, 1'b1);
        #1 reset = 1'b1;
        #1;
        m_bc = '0;
        m_mc = '0;
        chk("async_rst_flush", {31'd0, flush_indicator}, 32'd0);
        chk("async_rst_resolved", {31'd0, resolved_valid}, 32'd0);
        chk("async_rst_addr", {24'd0, address_to_branch}, 32'd0);
        chk("async_rst_branch_count", {28'd0, branch_count}, 32'd0);
        chk("async_rst_mispredict_count", {28'd0, mispredict_count}, 32'd0);
        look(32'h10, 1'b0, 8'h00);
        look(32'h20, 1'b0, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
